wb_queue: RTL and testbench

Writeback buffer that sits between the execute/memory stages and the register file's single write port. It accepts results from two producers (ALU and load unit) through valid/ready handshakes and holds them in a small in-order FIFO. It drains one entry per cycle onto the register file's regwrite/writereg/writedata port. It also supplies forwarding for the two register-file read ports, so decode sees values that are still queued.

---
 rtl/wb_queue_if.sv | 32 +++
 rtl/wb_queue.sv | 81 ++++++++
 tb/tb_wb_queue.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_queue_if.sv
// wb_queue_if: producer handshakes, register-file write port and forwarding lookups of the writeback queue.
interface wb_queue_if #(parameter int DEPTH = 4);
    localparam int CW = $clog2(DEPTH + 1);
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        regwrite;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic [4:0]  readreg1;
    logic [4:0]  readreg2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
    logic [CW-1:0] count;
    modport master (
        output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, readreg1, readreg2,
        input  mem_ready, alu_ready, regwrite, writereg, writedata,
               fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
    );
    modport slave (
        input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, readreg1, readreg2,
        output mem_ready, alu_ready, regwrite, writereg, writedata,
               fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
    );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback FIFO merging load/ALU results onto one register-file write port, with read forwarding.
module wb_queue #(parameter int DEPTH = 4) (
    input logic clk,
    input logic rst,
    wb_queue_if.slave wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [4:0]    r_rd [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_head, r_tail, w_alu_idx, w_idx;
    logic [CW-1:0] r_count;
    logic [CW:0]   w_free;
    logic          w_pop, w_mem_ready, w_alu_ready, w_mem_push, w_alu_push;
    logic          w_hit1, w_hit2;
    logic [31:0]   w_fwd1, w_fwd2;

    // free counts the slot released by this cycle's unconditional drain
    assign w_pop       = r_count != '0;
    assign w_free      = (CW+1)'(DEPTH) - {1'b0, r_count} + {{CW{1'b0}}, w_pop};
    assign w_mem_ready = w_free >= (CW+1)'(1);
    assign w_alu_ready = w_free >= (CW+1)'(wb.mem_valid ? 2 : 1);
    assign w_mem_push  = wb.mem_valid && w_mem_ready && wb.mem_rd != '0;
    assign w_alu_push  = wb.alu_valid && w_alu_ready && wb.alu_rd != '0;
    assign w_alu_idx   = r_tail + PW'(w_mem_push);

    assign wb.mem_ready = w_mem_ready;
    assign wb.alu_ready = w_alu_ready;
    assign wb.regwrite  = w_pop;
    assign wb.writereg  = w_pop ? r_rd[r_head] : '0;
    assign wb.writedata = w_pop ? r_data[r_head] : '0;
    assign wb.count     = r_count;
    assign wb.fwd1_hit  = w_hit1;
    assign wb.fwd2_hit  = w_hit2;
    assign wb.fwd1_data = w_fwd1;
    assign wb.fwd2_data = w_fwd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_mem_push) + PW'(w_alu_push);
            r_count <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
        end
    end

    // the load is the older instruction, so it takes tail and the ALU result tail+1
    always_ff @(posedge clk) begin
        if (!rst && w_mem_push) begin
            r_rd[r_tail]   <= wb.mem_rd;
            r_data[r_tail] <= wb.mem_data;
        end
        if (!rst && w_alu_push) begin
            r_rd[w_alu_idx]   <= wb.alu_rd;
            r_data[w_alu_idx] <= wb.alu_data;
        end
    end

    // scan oldest to youngest so the last match left standing is the youngest
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        w_fwd1 = '0;
        w_fwd2 = '0;
        w_idx  = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (CW'(i) < r_count && wb.readreg1 != '0 && r_rd[w_idx] == wb.readreg1) begin
                w_hit1 = 1'b1;
                w_fwd1 = r_data[w_idx];
            end
            if (CW'(i) < r_count && wb.readreg2 != '0 && r_rd[w_idx] == wb.readreg2) begin
                w_hit2 = 1'b1;
                w_fwd2 = r_data[w_idx];
            end
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed vectors for wb_queue plus a write-port/ready monitor against a reference queue.
module tb_wb_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_en = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [36:0] sbq [$];

    wb_queue_if #(.DEPTH(4)) wb ();
    wb_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .wb(wb));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb.mem_valid = 1'b0;
        wb.mem_rd    = '0;
        wb.mem_data  = '0;
        wb.alu_valid = 1'b0;
        wb.alu_rd    = '0;
        wb.alu_data  = '0;
    endtask

    task automatic push_mem(input logic [4:0] rd, input logic [31:0] d);
        wb.mem_valid = 1'b1;
        wb.mem_rd    = rd;
        wb.mem_data  = d;
    endtask

    task automatic push_alu(input logic [4:0] rd, input logic [31:0] d);
        wb.alu_valid = 1'b1;
        wb.alu_rd    = rd;
        wb.alu_data  = d;
    endtask

    // mid-cycle monitor: reference queue predicts count, readies and the write port
    always @(negedge clk) begin
        int n, fr;
        logic ovf, acc_m, acc_a;
        if (mon_en) begin
            n  = sbq.size();
            fr = 4 - n + ((n > 0) ? 1 : 0);
            acc_m = wb.mem_valid && (fr >= 1);
            acc_a = wb.alu_valid && (wb.mem_valid ? (fr >= 2) : (fr >= 1));
            chk("count", 32'(wb.count), 32'(n));
            chk("mem_ready", 32'(wb.mem_ready), 32'(fr >= 1));
            chk("alu_ready", 32'(wb.alu_ready), 32'(wb.mem_valid ? (fr >= 2) : (fr >= 1)));
            chk("regwrite", 32'(wb.regwrite), 32'(n > 0));
            if (n > 0) begin
                chk("writereg", 32'(wb.writereg), 32'(sbq[0][36:32]));
                chk("writedata", wb.writedata, sbq[0][31:0]);
                sbq.delete(0);
            end else begin
                chk("writereg_idle", 32'(wb.writereg), 32'd0);
                chk("writedata_idle", wb.writedata, 32'd0);
            end
            ovf = wb.count == 3'd4 && !wb.regwrite &&
                  ((wb.mem_valid && wb.mem_ready && wb.mem_rd != 0) ||
                   (wb.alu_valid && wb.alu_ready && wb.alu_rd != 0));
            chk("overflow", 32'(ovf), 32'd0);
            if (rst) sbq.delete();
            else begin
                if (acc_m && wb.mem_rd != 0) sbq.push_back({wb.mem_rd, wb.mem_data});
                if (acc_a && wb.alu_rd != 0) sbq.push_back({wb.alu_rd, wb.alu_data});
            end
        end
    end

    initial begin
        int mseq, aseq, maxc, guard;
        idle();
        wb.readreg1 = '0;
        wb.readreg2 = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(wb.count), 0);
        chk("rst_regwrite", 32'(wb.regwrite), 0);
        chk("rst_writereg", 32'(wb.writereg), 0);
        chk("rst_writedata", wb.writedata, 0);
        chk("rst_fwd1_hit", 32'(wb.fwd1_hit), 0);
        chk("rst_fwd2_hit", 32'(wb.fwd2_hit), 0);
        chk("rst_fwd1_data", wb.fwd1_data, 0);
        chk("rst_mem_ready", 32'(wb.mem_ready), 1);
        chk("rst_alu_ready", 32'(wb.alu_ready), 1);
        mon_en = 1'b1;

        // single ALU write
        push_alu(5'd5, 32'hDEADBEEF);
        wb.readreg1 = 5'd5;
        #1;
        chk("alu1_no_same_cycle_fwd", 32'(wb.fwd1_hit), 0);
        tick();
        idle();
        #1;
        chk("alu1_regwrite", 32'(wb.regwrite), 1);
        chk("alu1_writereg", 32'(wb.writereg), 5);
        chk("alu1_writedata", wb.writedata, 32'hDEADBEEF);
        chk("alu1_fwd1_hit", 32'(wb.fwd1_hit), 1);
        chk("alu1_fwd1_data", wb.fwd1_data, 32'hDEADBEEF);
        tick();
        #1;
        chk("alu1_drained_regwrite", 32'(wb.regwrite), 0);
        chk("alu1_drained_fwd1_hit", 32'(wb.fwd1_hit), 0);

        // simultaneous push to the same register: load older, ALU younger
        wb.readreg1 = '0;
        wb.readreg2 = 5'd3;
        push_mem(5'd3, 32'h11);
        push_alu(5'd3, 32'h22);
        #1;
        chk("both_mem_ready", 32'(wb.mem_ready), 1);
        chk("both_alu_ready", 32'(wb.alu_ready), 1);
        tick();
        idle();
        #1;
        chk("both_first_data", wb.writedata, 32'h11);
        chk("both_first_fwd2_hit", 32'(wb.fwd2_hit), 1);
        chk("both_first_fwd2", wb.fwd2_data, 32'h22);
        tick();
        #1;
        chk("both_second_data", wb.writedata, 32'h22);
        chk("both_second_fwd2", wb.fwd2_data, 32'h22);
        tick();
        #1;
        chk("both_done_fwd2_hit", 32'(wb.fwd2_hit), 0);

        // x0 results complete the handshake but are never queued
        push_alu(5'd0, 32'h55);
        #1;
        chk("x0_alu_ready", 32'(wb.alu_ready), 1);
        tick();
        idle();
        #1;
        chk("x0_count", 32'(wb.count), 0);
        chk("x0_regwrite", 32'(wb.regwrite), 0);
        push_mem(5'd7, 32'h77);
        push_alu(5'd0, 32'h55);
        wb.readreg1 = 5'd0;
        wb.readreg2 = 5'd7;
        tick();
        idle();
        #1;
        chk("x0_mixed_count", 32'(wb.count), 1);
        chk("x0_fwd1_hit", 32'(wb.fwd1_hit), 0);
        chk("x0_fwd2_hit", 32'(wb.fwd2_hit), 1);
        chk("x0_fwd2_data", wb.fwd2_data, 32'h77);
        tick();

        // reset mid-operation with three entries queued
        push_mem(5'd1, 32'hA1);
        push_alu(5'd2, 32'hA2);
        tick();
        push_mem(5'd3, 32'hA3);
        push_alu(5'd4, 32'hA4);
        tick();
        idle();
        wb.readreg1 = 5'd4;
        #1;
        chk("mid_count", 32'(wb.count), 3);
        chk("mid_fwd1", wb.fwd1_data, 32'hA4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(wb.count), 0);
        chk("mid_rst_regwrite", 32'(wb.regwrite), 0);
        chk("mid_rst_mem_ready", 32'(wb.mem_ready), 1);
        chk("mid_rst_alu_ready", 32'(wb.alu_ready), 1);
        chk("mid_rst_fwd1_hit", 32'(wb.fwd1_hit), 0);
        tick();
        tick();

        // back-pressure: both producers always valid, values held until accepted
        mseq = 0;
        aseq = 0;
        maxc = 0;
        wb.readreg1 = '0;
        wb.readreg2 = '0;
        for (int k = 0; k < 16; k++) begin
            push_mem(5'(1 + mseq % 15), 32'h1000 + 32'(mseq));
            push_alu(5'(16 + aseq % 15), 32'h2000 + 32'(aseq));
            #1;
            if (int'(wb.count) > maxc) maxc = int'(wb.count);
            if (wb.mem_ready) mseq++;
            if (wb.alu_ready) aseq++;
            tick();
        end
        idle();
        #1;
        chk("bp_max_count", 32'(maxc), 4);
        chk("bp_full_count", 32'(wb.count), 4);
        chk("bp_mem_accepts", 32'(mseq), 16);
        chk("bp_alu_accepts", 32'(aseq), 3);
        guard = 0;
        while (wb.count != 0 && guard < 10) begin
            tick();
            guard++;
        end
        chk("bp_drained", 32'(wb.count), 0);

        // wrap-around: ten sequential writes through a four-entry ring
        for (int i = 1; i <= 10; i++) begin
            push_alu(5'(i), 32'h100 + 32'(i));
            tick();
        end
        idle();
        #1;
        chk("wrap_last_reg", 32'(wb.writereg), 10);
        chk("wrap_last_data", wb.writedata, 32'h10A);
        tick();
        #1;
        chk("wrap_empty", 32'(wb.count), 0);
        tick();
        chk("ref_queue_empty", 32'(sbq.size()), 0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
